ntt_bank_addr_gen: RTL and testbench
====================================

// Module: ntt_bank_addr_gen
// PURPOSE
//  Read/write initiator for the 4-bank conflict-free coefficient memory.
//  Walks every NTT stage and emits four coefficient accesses per cycle, i.e.
//  two radix-2 butterflies. Each access is a {bank idx, bank address} pair
//  driven onto newadd0..3_idx / newadd0..3 together with ren/wen. Also emits
//  two twiddle addresses per cycle and a start/busy/done handshake to the top FSM.
// PARAMETERS
//  LOGN   11  log2(coefficient count); N=2048, 4 banks x 512 words
//  BAW    9   bank address width, fixed at LOGN-2
//  GAP    10  idle cycles after each stage so the memory's 8-cycle delayed
//             write-back drains before the next stage reads
// PORTS
//  clk          in   1      clock, single domain
//  rstn         in   1      asynchronous active-low reset
//  start        in   1      1-cycle pulse; accepted only in IDLE
//  inv          in   1      sampled with start: 0=forward (s=0..LOGN-1), 1=inverse (s=LOGN-1..0)
//  busy         out  1      high from the cycle after start until done
//  done         out  1      1-cycle pulse after the last stage's GAP
//  ren          out  1      read strobe for all banks
//  wen          out  1      write strobe, equal to ren; the memory delays it internally
//  newaddK_idx  out  2      K=0..3 bank select for slot K
//  newaddK      out  BAW    K=0..3 bank word address for slot K
//  tw_addr0     out  LOGN   twiddle address, butterfly A
//  tw_addr1     out  LOGN   twiddle address, butterfly B
//  stage        out  4      current stage number s, for the BFU mode mux
// BEHAVIOUR
//  Reset: state=IDLE; every output 0, including all newadd*, tw_addr* and stage.
//  FSM states IDLE, RUN, GAP, DONE:
//   IDLE->RUN on start. Latch inv, set s=0 (inv=0) or s=LOGN-1 (inv=1), set c=0.
//   RUN: c counts 0..N/4-1 (0..511). ren=wen=1 every cycle. At c=511 go to GAP.
//   GAP: ren=wen=0 for GAP cycles. Then either advance s and go to RUN with c=0,
//        or, if the last stage just finished, go to DONE.
//   DONE: done=1 and busy=0 for one cycle, then IDLE.
//  Index math, all registered, outputs valid in the same cycle as ren:
//   h=2^s. Butterfly b=2c+j (j=0 -> A, j=1 -> B). o=b&(h-1).
//   top=((b>>s)<<(s+1))|o, bot=top+h.
//   Slot0=topA, slot1=botA, slot2=topB, slot3=botB.
//  Bank map for coefficient x (LOGN bits):
//   idx={^x[LOGN-1:1], x[0]}, addr=x[LOGN-1:2]. The map is a bijection, and the four
//   slots always land in four distinct banks. Bench must assert this every ren cycle.
//  tw_addrJ=h+o for butterfly J. At s=0 both equal 1.
//  Counters wrap only via FSM; no arithmetic overflow is possible (top,bot<N).
//  start while busy is ignored. start and DONE in the same cycle: start ignored.
//  Async reset mid-run: immediate return to IDLE, all outputs 0. No done pulse.
//  Latency: start at cycle T -> first ren at T+1.
//   done at T+1+LOGN*(N/4+GAP) = T+5743 with defaults.
// TESTING
//  1. Reset, start, inv=0, cycle T+1: slots 0..3 = {idx0,a0},{idx1,a0},{idx2,a0},{idx3,a0};
//     tw_addr0=tw_addr1=1; stage=0.
//  2. Stage 3, c=5: top/bot=18,26,19,27 -> idx/addr = 0/4, 2/6, 1/4, 3/6;
//     tw_addr0=10, tw_addr1=11.
//  3. Full forward run: ren high exactly 11x512 cycles. GAP holes are 10 cycles.
//     done exactly at T+5743. Every bank/addr pair is read once per stage.
//  4. inv=1: first RUN stage=10, slot0=0 -> idx0/addr0, slot1=1024 -> idx2/addr256;
//     stage sequence 10..0.
//  5. start pulses during RUN and GAP have no effect. Assert rstn low at c=200 of
//     stage 4: outputs 0 next edge; new start then runs a full fresh pass.
//  6. Random-cycle check: the four idx values are always distinct.
//     Each addr is reconstructed back to x against a reference model.

Source files
------------

// File: rtl/ntt_bank_addr_gen.sv
// NTT coefficient/twiddle address generator for a 4-bank conflict-free memory.
// Emits two radix-2 butterflies (four coefficient accesses) per cycle, stage by stage.
module ntt_bank_addr_gen #(
   parameter int LOGN = 11,
   parameter int BAW  = LOGN - 2,
   parameter int GAP  = 10
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic            inv,
   output logic            busy,
   output logic            done,
   output logic            ren,
   output logic            wen,
   output logic [1:0]      newadd0_idx,
   output logic [1:0]      newadd1_idx,
   output logic [1:0]      newadd2_idx,
   output logic [1:0]      newadd3_idx,
   output logic [BAW-1:0]  newadd0,
   output logic [BAW-1:0]  newadd1,
   output logic [BAW-1:0]  newadd2,
   output logic [BAW-1:0]  newadd3,
   output logic [LOGN-1:0] tw_addr0,
   output logic [LOGN-1:0] tw_addr1,
   output logic [3:0]      stage
);

   localparam int GW = $clog2(GAP + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_GAP,
      S_DONE
   } state_t;

   state_t         state_q, state_n;
   logic [BAW-1:0] c_q, c_n;
   logic [3:0]     s_q, s_n;
   logic [GW-1:0]  g_q, g_n;
   logic           inv_q, inv_n;
   logic           last_stage;

   function automatic logic [1:0] bank_idx(input logic [LOGN-1:0] x);
      return {^x[LOGN-1:1], x[0]};
   endfunction

   function automatic logic [BAW-1:0] bank_addr(input logic [LOGN-1:0] x);
      return x[LOGN-1:2];
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         c_q     <= '0;
         s_q     <= '0;
         g_q     <= '0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         c_q     <= c_n;
         s_q     <= s_n;
         g_q     <= g_n;
         inv_q   <= inv_n;
      end
   end

   always_comb begin
      state_n    = state_q;
      c_n        = c_q;
      s_n        = s_q;
      g_n        = g_q;
      inv_n      = inv_q;
      last_stage = inv_q ? (s_q == 4'd0) : (s_q == 4'(LOGN - 1));
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_n = S_RUN;
               inv_n   = inv;
               s_n     = inv ? 4'(LOGN - 1) : 4'd0;
               c_n     = '0;
            end
         end
         S_RUN: begin
            c_n = c_q + 1'b1;
            if (c_q == '1) begin
               state_n = S_GAP;
               c_n     = '0;
               g_n     = '0;
            end
         end
         S_GAP: begin
            g_n = g_q + 1'b1;
            if (g_q == GW'(GAP - 1)) begin
               if (last_stage) begin
                  state_n = S_DONE;
               end else begin
                  state_n = S_RUN;
                  s_n     = inv_q ? s_q - 4'd1 : s_q + 4'd1;
               end
            end
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Outputs are registered from next-state values so they line up with ren.
   logic            run_n, busy_n, done_n;
   logic [LOGN-1:0] h, msk;
   logic [LOGN-1:0] b [2];
   logic [LOGN-1:0] o [2];
   logic [LOGN-1:0] top [2];
   logic [LOGN-1:0] bot [2];
   logic [LOGN-1:0] tw_n [2];
   logic [LOGN-1:0] x_n [4];
   logic [1:0]      idx_n [4];
   logic [BAW-1:0]  addr_n [4];

   always_comb begin
      run_n  = (state_n == S_RUN);
      busy_n = (state_n == S_RUN) || (state_n == S_GAP);
      done_n = (state_n == S_DONE);
      h      = LOGN'(1) << s_n;
      msk    = h - 1'b1;
      b[0]   = {1'b0, c_n, 1'b0};
      b[1]   = {1'b0, c_n, 1'b1};
      for (int j = 0; j < 2; j++) begin
         o[j]    = b[j] & msk;
         top[j]  = ((b[j] >> s_n) << (s_n + 4'd1)) | o[j];
         bot[j]  = top[j] + h;
         tw_n[j] = run_n ? h + o[j] : '0;
      end
      x_n[0] = top[0];
      x_n[1] = bot[0];
      x_n[2] = top[1];
      x_n[3] = bot[1];
      for (int k = 0; k < 4; k++) begin
         idx_n[k]  = run_n ? bank_idx(x_n[k]) : 2'd0;
         addr_n[k] = run_n ? bank_addr(x_n[k]) : '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         ren         <= 1'b0;
         wen         <= 1'b0;
         newadd0_idx <= '0;
         newadd1_idx <= '0;
         newadd2_idx <= '0;
         newadd3_idx <= '0;
         newadd0     <= '0;
         newadd1     <= '0;
         newadd2     <= '0;
         newadd3     <= '0;
         tw_addr0    <= '0;
         tw_addr1    <= '0;
         stage       <= '0;
      end else begin
         busy        <= busy_n;
         done        <= done_n;
         ren         <= run_n;
         wen         <= run_n;
         newadd0_idx <= idx_n[0];
         newadd1_idx <= idx_n[1];
         newadd2_idx <= idx_n[2];
         newadd3_idx <= idx_n[3];
         newadd0     <= addr_n[0];
         newadd1     <= addr_n[1];
         newadd2     <= addr_n[2];
         newadd3     <= addr_n[3];
         tw_addr0    <= tw_n[0];
         tw_addr1    <= tw_n[1];
         stage       <= busy_n ? s_n : 4'd0;
      end
   end

endmodule

// File: tb/tb_ntt_bank_addr_gen.sv
// Bench for ntt_bank_addr_gen: timeline model, butterfly tables, vectors.
// Covers forward/inverse passes, spurious starts, mid-run reset.
module tb_ntt_bank_addr_gen;

   localparam int LOGN  = 11;
   localparam int BAW   = 9;
   localparam int GAP   = 10;
   localparam int N     = 2048;
   localparam int RUNC  = 512;
   localparam int SLEN  = RUNC + GAP;
   localparam int TOTAL = 1 + LOGN * SLEN;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            start = 1'b0;
   logic            inv = 1'b0;
   logic            busy, done, ren, wen;
   logic [1:0]      newadd0_idx, newadd1_idx, newadd2_idx, newadd3_idx;
   logic [BAW-1:0]  newadd0, newadd1, newadd2, newadd3;
   logic [LOGN-1:0] tw_addr0, tw_addr1;
   logic [3:0]      stage;

   always #5 clk = ~clk;

   ntt_bank_addr_gen #(.LOGN(LOGN), .BAW(BAW), .GAP(GAP)) dut (
      .clk(clk), .rstn(rstn), .start(start), .inv(inv),
      .busy(busy), .done(done), .ren(ren), .wen(wen),
      .newadd0_idx(newadd0_idx), .newadd1_idx(newadd1_idx),
      .newadd2_idx(newadd2_idx), .newadd3_idx(newadd3_idx),
      .newadd0(newadd0), .newadd1(newadd1),
      .newadd2(newadd2), .newadd3(newadd3),
      .tw_addr0(tw_addr0), .tw_addr1(tw_addr1), .stage(stage)
   );

   int n_checks = 0;
   int n_err = 0;
   int tops [LOGN][N/2];
   bit seen [N];
   int seen_cnt;

   typedef struct {
      bit          inv;
      int          s;
      int          c;
      logic [7:0]  idx;
      logic [35:0] addr;
      logic [21:0] tw;
   } vec_t;
   vec_t vecs [4];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] outs();
      return 128'({busy, done, ren, wen,
                   newadd0_idx, newadd1_idx, newadd2_idx, newadd3_idx,
                   newadd0, newadd1, newadd2, newadd3,
                   tw_addr0, tw_addr1, stage});
   endfunction

   task automatic clear_seen();
      foreach (seen[i]) seen[i] = 1'b0;
      seen_cnt = 0;
   endtask

   task automatic check_cycle(input int t, input bit pinv);
      int k, r, s, h, x, xe;
      bit run, ok;
      logic [1:0] ix [4];
      logic [8:0] ad [4];
      run = 1'b0;
      s = 0;
      r = 0;
      if (t < TOTAL) begin
         k = (t - 1) / SLEN;
         r = (t - 1) % SLEN;
         s = pinv ? LOGN - 1 - k : k;
         run = (r < RUNC);
         chk("ctrl", 128'({ren, wen, busy, done, stage}),
             128'({run, run, 1'b1, 1'b0, 4'(s)}));
      end else begin
         chk("ctrl_done", 128'({ren, wen, busy, done, stage}),
             128'({4'b0001, 4'd0}));
      end
      if (run) begin
         ix = '{newadd0_idx, newadd1_idx, newadd2_idx, newadd3_idx};
         ad = '{newadd0, newadd1, newadd2, newadd3};
         ok = 1'b1;
         for (int a = 0; a < 4; a++)
            for (int bb = a + 1; bb < 4; bb++)
               if (ix[a] == ix[bb]) ok = 1'b0;
         chk("bank_distinct", 128'(ok), 128'(1));
         h = 1 << s;
         for (int q = 0; q < 4; q++) begin
            xe = tops[s][2 * r + q / 2] + ((q % 2 == 1) ? h : 0);
            x = (int'(ad[q]) << 2)
                | ((int'(ix[q][1]) ^ ($countones(ad[q]) & 1)) << 1)
                | int'(ix[q][0]);
            chk("slot_x", 128'({q, x}), 128'({q, xe}));
            if (x >= 0 && x < N && !seen[x]) begin
               seen[x] = 1'b1;
               seen_cnt++;
            end
         end
         chk("tw", 128'({tw_addr0, tw_addr1}),
             128'({11'(h + (2 * r) % h), 11'(h + (2 * r + 1) % h)}));
         foreach (vecs[v])
            if (vecs[v].inv == pinv && vecs[v].s == s && vecs[v].c == r)
               chk("vec", 128'({newadd0_idx, newadd1_idx, newadd2_idx,
                                newadd3_idx, newadd0, newadd1, newadd2,
                                newadd3, tw_addr0, tw_addr1}),
                   128'({vecs[v].idx, vecs[v].addr, vecs[v].tw}));
         if (r == RUNC - 1) begin
            chk("stage_cover", 128'(seen_cnt), 128'(N));
            clear_seen();
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         start = 1'b0;
         chk("idle", 128'({ren, wen, busy, done, stage}), 128'(0));
      end
   endtask

   task automatic run_pass(input bit pinv, input bit spur, input int abort_t);
      int t1, t2;
      idle_cycles($urandom_range(1, 8));
      clear_seen();
      t1 = $urandom_range(2, RUNC);
      t2 = 1 + $urandom_range(0, LOGN - 2) * SLEN + RUNC
           + $urandom_range(0, GAP - 1);
      inv = pinv;
      start = 1'b1;
      for (int t = 1; t <= TOTAL; t++) begin
         @(negedge clk);
         start = 1'b0;
         inv = pinv;
         check_cycle(t, pinv);
         if (t == abort_t) begin
            rstn = 1'b0;
            @(posedge clk);
            #1;
            chk("abort_reset", outs(), 128'(0));
            @(negedge clk);
            rstn = 1'b1;
            idle_cycles(4);
            return;
         end
         if (spur && (t == t1 || t == t2 || t == TOTAL)) begin
            start = 1'b1;
            inv = ~pinv;
         end
      end
      idle_cycles(3);
   endtask

   initial begin
      for (int s = 0; s < LOGN; s++) begin
         int n;
         n = 0;
         for (int x = 0; x < N; x++)
            if (((x >> s) & 1) == 0) begin
               tops[s][n] = x;
               n++;
            end
      end
      vecs[0] = '{1'b0, 0, 0, {2'd0, 2'd1, 2'd2, 2'd3},
                  {9'd0, 9'd0, 9'd0, 9'd0}, {11'd1, 11'd1}};
      vecs[1] = '{1'b0, 3, 5, {2'd0, 2'd2, 2'd1, 2'd3},
                  {9'd4, 9'd6, 9'd4, 9'd6}, {11'd10, 11'd11}};
      vecs[2] = '{1'b1, 10, 0, {2'd0, 2'd2, 2'd1, 2'd3},
                  {9'd0, 9'd256, 9'd0, 9'd256}, {11'd1024, 11'd1025}};
      vecs[3] = '{1'b0, 10, 511, {2'd2, 2'd0, 2'd3, 2'd1},
                  {9'd255, 9'd511, 9'd255, 9'd511}, {11'd2046, 11'd2047}};

      repeat (3) @(negedge clk);
      chk("reset", outs(), 128'(0));
      rstn = 1'b1;
      idle_cycles(2);

      run_pass(1'b0, 1'b0, 0);
      run_pass(1'b1, 1'b1, 0);
      run_pass(1'b0, 1'b0, 1 + 4 * SLEN + 200);
      run_pass(1'($urandom_range(0, 1)), 1'b1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
